// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: LCR bit positions, FIFO entry
// geometry, receiver state encodings and the frame-length helper.
package uart_receiver_pkg;

   localparam int unsigned UART_LC_BITS        = 0;  // [1:0] word length - 5
   localparam int unsigned UART_LC_SB          = 2;
   localparam int unsigned UART_LC_PE          = 3;
   localparam int unsigned UART_LC_EP          = 4;
   localparam int unsigned UART_LC_SP          = 5;
   localparam int unsigned UART_FIFO_COUNTER_W = 5;
   localparam int unsigned UART_FIFO_REC_WIDTH = 11;

   typedef enum logic [2:0] {
      r_idle       = 3'd0,
      r_rec_start  = 3'd1,
      r_rec_bit    = 3'd2,
      r_rec_parity = 3'd3,
      r_rec_stop   = 3'd4,
      r_push       = 3'd5
   } rstate_t;

   // Start + data + optional parity + one stop bit, range 7..11.
   function automatic logic [3:0] frame_bits(input logic [7:0] lc);
      return 4'd7 + {2'b00, lc[UART_LC_BITS +: 2]} + {3'b000, lc[UART_LC_PE]};
   endfunction

endpackage

// File: rtl/uart_receiver_rx_fifo.sv
// Receive FIFO: stores {data, break, parity error, framing error} entries,
// tracks per-entry error flags and a sticky overrun.
module uart_rx_fifo
   import uart_receiver_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = UART_FIFO_COUNTER_W,
   parameter int unsigned WIDTH = UART_FIFO_REC_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             fifo_reset,
   input  logic             reset_status,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [CNT_W-1:0] count,
   output logic             error_bit,
   output logic             overrun
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [DEPTH-1:0] err, err_next;
   logic             full, empty, do_push, do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign error_bit = |err;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= data_in;
   end

   // Pop clears before push sets so a full-FIFO push+pop on the same slot keeps the new flag.
   always_comb begin
      err_next = err;
      if (reset_status)
         err_next = '0;
      if (do_pop)
         err_next[rd_ptr] = 1'b0;
      if (do_push)
         err_next[wr_ptr] = |data_in[2:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err      <= '0;
         overrun  <= 1'b0;
         data_out <= '0;
      end else begin
         if (fifo_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= '0;
         end else begin
            if (do_push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
               count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
               count <= count - CNT_W'(1);
            err <= err_next;
         end
         if (push && full && !do_pop)
            overrun <= 1'b1;
         else if (reset_status)
            overrun <= 1'b0;
         data_out <= empty ? '0 : mem[rd_ptr];
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 16550-style receive path: 16x oversampled frame decoder, break and
// character-timeout detection, feeding the receive FIFO.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int unsigned RF_DEPTH = 16,
   parameter int unsigned RF_CNT_W = UART_FIFO_COUNTER_W
) (
   input  logic                clk,
   input  logic                wb_rst_n,
   input  logic                enable,
   input  logic [7:0]          lcr,
   input  logic                srx_pad_i,
   input  logic                rf_pop,
   input  logic                rx_reset,
   input  logic                lsr_mask,
   output logic [10:0]         rf_data_out,
   output logic [RF_CNT_W-1:0] rf_count,
   output logic                rf_error_bit,
   output logic                rf_overrun,
   output logic [2:0]          rstate,
   output logic                break_o,
   output logic                timeout_o
);

   rstate_t     state;
   logic        srx_meta, srx;
   logic [3:0]  frame_len;
   logic [7:0]  brc_load;
   logic [9:0]  toc_load;
   logic [3:0]  tick_cnt;
   logic [2:0]  bit_idx, last_bit;
   logic [7:0]  rdata;
   logic        par_acc, expected_par;
   logic        pe, fe, brk, stop_wait, brk_lock, push;
   logic [7:0]  brk_cnt;
   logic [9:0]  toc_cnt;
   logic        unused_lcr;

   assign unused_lcr = ^{lcr[7:6], lcr[UART_LC_SB]};
   assign frame_len  = frame_bits(lcr);
   assign brc_load   = {frame_len, 4'b0000} - 8'd1;
   assign toc_load   = {frame_len, 6'b000000} - 10'd1;
   assign last_bit   = 3'd4 + {1'b0, lcr[UART_LC_BITS +: 2]};
   assign rstate     = state;
   assign break_o    = (brk_cnt == '0) && !srx;
   assign timeout_o  = (toc_cnt == '0) && (rf_count != '0);

   always_comb begin
      expected_par = 1'b0;
      if (lcr[UART_LC_SP])
         expected_par = ~lcr[UART_LC_EP];
      else
         expected_par = lcr[UART_LC_EP] ? par_acc : ~par_acc;
   end

   always_ff @(posedge clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         srx_meta <= 1'b1;
         srx      <= 1'b1;
      end else begin
         srx_meta <= srx_pad_i;
         srx      <= srx_meta;
      end
   end

   // An all-zero frame with a low stop bit is held at the stop sample until the
   // line either rises (framing error) or the break counter expires (break entry).
   always_ff @(posedge clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state     <= r_idle;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         rdata     <= '0;
         par_acc   <= 1'b0;
         pe        <= 1'b0;
         fe        <= 1'b0;
         brk       <= 1'b0;
         stop_wait <= 1'b0;
         brk_lock  <= 1'b0;
         push      <= 1'b0;
      end else begin
         push <= 1'b0;
         if (srx)
            brk_lock <= 1'b0;
         case (state)
            r_idle: begin
               if (enable && !srx && !brk_lock) begin
                  tick_cnt <= 4'd7;
                  state    <= r_rec_start;
               end
            end
            r_rec_start: begin
               if (enable) begin
                  if (tick_cnt != '0)
                     tick_cnt <= tick_cnt - 4'd1;
                  else if (srx)
                     state <= r_idle;
                  else begin
                     tick_cnt  <= 4'd15;
                     bit_idx   <= '0;
                     rdata     <= '0;
                     par_acc   <= 1'b0;
                     pe        <= 1'b0;
                     fe        <= 1'b0;
                     brk       <= 1'b0;
                     stop_wait <= 1'b0;
                     state     <= r_rec_bit;
                  end
               end
            end
            r_rec_bit: begin
               if (enable) begin
                  if (tick_cnt != '0)
                     tick_cnt <= tick_cnt - 4'd1;
                  else begin
                     rdata[bit_idx] <= srx;
                     par_acc        <= par_acc ^ srx;
                     tick_cnt       <= 4'd15;
                     bit_idx        <= bit_idx + 3'd1;
                     if (bit_idx == last_bit)
                        state <= lcr[UART_LC_PE] ? r_rec_parity : r_rec_stop;
                  end
               end
            end
            r_rec_parity: begin
               if (enable) begin
                  if (tick_cnt != '0)
                     tick_cnt <= tick_cnt - 4'd1;
                  else begin
                     pe       <= (srx != expected_par);
                     tick_cnt <= 4'd15;
                     state    <= r_rec_stop;
                  end
               end
            end
            r_rec_stop: begin
               if (enable) begin
                  if (tick_cnt != '0)
                     tick_cnt <= tick_cnt - 4'd1;
                  else if (srx || (rdata != '0)) begin
                     fe    <= ~srx | stop_wait;
                     push  <= 1'b1;
                     state <= r_push;
                  end else if (brk_cnt == '0) begin
                     brk      <= 1'b1;
                     pe       <= 1'b0;
                     fe       <= 1'b0;
                     brk_lock <= 1'b1;
                     push     <= 1'b1;
                     state    <= r_push;
                  end else
                     stop_wait <= 1'b1;
               end
            end
            r_push:  state <= r_idle;
            default: state <= r_idle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         brk_cnt <= '0;
         toc_cnt <= '0;
      end else begin
         if (srx)
            brk_cnt <= brc_load;
         else if (enable && (brk_cnt != '0))
            brk_cnt <= brk_cnt - 8'd1;

         if (push || rf_pop || rx_reset || (rf_count == '0))
            toc_cnt <= toc_load;
         else if (enable && (toc_cnt != '0))
            toc_cnt <= toc_cnt - 10'd1;
      end
   end

   uart_rx_fifo #(
      .DEPTH (RF_DEPTH),
      .CNT_W (RF_CNT_W),
      .WIDTH (UART_FIFO_REC_WIDTH)
   ) u_rx_fifo (
      .clk          (clk),
      .rst_n        (wb_rst_n),
      .push         (push),
      .pop          (rf_pop),
      .fifo_reset   (rx_reset),
      .reset_status (lsr_mask),
      .data_in      ({rdata, brk, pe, fe}),
      .data_out     (rf_data_out),
      .count        (rf_count),
      .error_bit    (rf_error_bit),
      .overrun      (rf_overrun)
   );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: each test task drives serial frames and
// checks FIFO contents, flags and state against hand-computed values.
module tb_uart_receiver;

   logic        clk = 1'b0;
   logic        wb_rst_n, enable, srx_pad_i, rf_pop, rx_reset, lsr_mask;
   logic [7:0]  lcr;
   logic [10:0] rf_data_out;
   logic [4:0]  rf_count;
   logic        rf_error_bit, rf_overrun, break_o, timeout_o;
   logic [2:0]  rstate;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   uart_receiver #(.RF_DEPTH(16), .RF_CNT_W(5)) dut (
      .clk          (clk),
      .wb_rst_n     (wb_rst_n),
      .enable       (enable),
      .lcr          (lcr),
      .srx_pad_i    (srx_pad_i),
      .rf_pop       (rf_pop),
      .rx_reset     (rx_reset),
      .lsr_mask     (lsr_mask),
      .rf_data_out  (rf_data_out),
      .rf_count     (rf_count),
      .rf_error_bit (rf_error_bit),
      .rf_overrun   (rf_overrun),
      .rstate       (rstate),
      .break_o      (break_o),
      .timeout_o    (timeout_o)
   );

   task automatic tick(input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         enable = 1'b1;
         @(negedge clk);
         enable = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic line(input logic b, input int unsigned n);
      srx_pad_i = b;
      tick(n);
   endtask

   task automatic send_frame(input logic [7:0] d, input int unsigned nbits,
                             input logic par_en, input logic par_bit, input logic stop_bit);
      line(1'b0, 16);
      for (int i = 0; i < int'(nbits); i++)
         line(d[i], 16);
      if (par_en)
         line(par_bit, 16);
      line(stop_bit, 16);
      srx_pad_i = 1'b1;
   endtask

   task automatic pop_one();
      rf_pop = 1'b1;
      @(negedge clk);
      rf_pop = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({rstate, rf_count, rf_error_bit, rf_overrun, break_o, timeout_o} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0", {rstate, rf_count, rf_error_bit, rf_overrun, break_o, timeout_o});
      end
      n_tests++;
      if (rf_data_out !== 11'h000) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 000", rf_data_out);
      end
      wb_rst_n = 1'b1;
      tick(20);
   endtask

   task automatic test_8n1();
      lcr = 8'h03;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      tick(4);
      n_tests++;
      if (rf_count !== 5'd1) begin
         n_fail++;
         $display("FAIL a5_count: got %0d required 1", rf_count);
      end
      n_tests++;
      if (rf_data_out !== 11'h528) begin
         n_fail++;
         $display("FAIL a5_data: got %h required 528", rf_data_out);
      end
      n_tests++;
      if ({rstate, rf_error_bit} !== 4'b0000) begin
         n_fail++;
         $display("FAIL a5_state_err: got %b required 0000", {rstate, rf_error_bit});
      end
      pop_one();
      n_tests++;
      if (rf_count !== 5'd0) begin
         n_fail++;
         $display("FAIL a5_pop: got %0d required 0", rf_count);
      end
   endtask

   task automatic test_parity();
      lcr = 8'h1A;
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
      tick(4);
      n_tests++;
      if (rf_data_out !== 11'h1AA) begin
         n_fail++;
         $display("FAIL par_bad_data: got %h required 1aa", rf_data_out);
      end
      n_tests++;
      if (rf_error_bit !== 1'b1) begin
         n_fail++;
         $display("FAIL par_err_bit: got %b required 1", rf_error_bit);
      end
      pop_one();
      n_tests++;
      if (rf_error_bit !== 1'b0) begin
         n_fail++;
         $display("FAIL par_err_after_pop: got %b required 0", rf_error_bit);
      end
      send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
      tick(4);
      n_tests++;
      if ({rf_data_out, rf_error_bit} !== {11'h1A8, 1'b0}) begin
         n_fail++;
         $display("FAIL par_good: got %h/%b required 1a8/0", rf_data_out, rf_error_bit);
      end
      pop_one();
   endtask

   task automatic test_framing();
      lcr = 8'h03;
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
      tick(30);
      n_tests++;
      if ({rf_count, rf_data_out} !== {5'd1, 11'h2D1}) begin
         n_fail++;
         $display("FAIL fe_entry: got count %0d data %h required 1/2d1", rf_count, rf_data_out);
      end
      n_tests++;
      if (rf_error_bit !== 1'b1) begin
         n_fail++;
         $display("FAIL fe_err_bit: got %b required 1", rf_error_bit);
      end
      lsr_mask = 1'b1;
      @(negedge clk);
      lsr_mask = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({rf_error_bit, rf_count} !== {1'b0, 5'd1}) begin
         n_fail++;
         $display("FAIL fe_lsr_mask: got err %b count %0d required 0/1", rf_error_bit, rf_count);
      end
      pop_one();
   endtask

   task automatic test_glitch();
      line(1'b0, 3);
      n_tests++;
      if (rstate !== 3'd1) begin
         n_fail++;
         $display("FAIL glitch_start: got %0d required 1", rstate);
      end
      line(1'b1, 20);
      n_tests++;
      if ({rstate, rf_count} !== {3'd0, 5'd0}) begin
         n_fail++;
         $display("FAIL glitch_idle: got state %0d count %0d required 0/0", rstate, rf_count);
      end
   endtask

   task automatic test_break();
      lcr = 8'h03;
      line(1'b0, 150);
      n_tests++;
      if (break_o !== 1'b0) begin
         n_fail++;
         $display("FAIL break_early: got %b required 0", break_o);
      end
      line(1'b0, 15);
      n_tests++;
      if (break_o !== 1'b1) begin
         n_fail++;
         $display("FAIL break_rise: got %b required 1", break_o);
      end
      line(1'b0, 135);
      n_tests++;
      if ({rf_count, rf_data_out} !== {5'd1, 11'h004}) begin
         n_fail++;
         $display("FAIL break_entry: got count %0d data %h required 1/004", rf_count, rf_data_out);
      end
      line(1'b1, 20);
      n_tests++;
      if ({rf_count, break_o} !== {5'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL break_release: got count %0d break %b required 1/0", rf_count, break_o);
      end
      pop_one();
   endtask

   task automatic test_overrun();
      lcr = 8'h03;
      for (int i = 0; i < 17; i++) begin
         send_frame(8'(i + 16), 8, 1'b0, 1'b0, 1'b1);
         tick(2);
         if (i == 15) begin
            n_tests++;
            if ({rf_count, rf_overrun} !== {5'd16, 1'b0}) begin
               n_fail++;
               $display("FAIL ovr_full: got count %0d ovr %b required 16/0", rf_count, rf_overrun);
            end
         end
      end
      n_tests++;
      if ({rf_count, rf_overrun, rf_data_out} !== {5'd16, 1'b1, 11'h080}) begin
         n_fail++;
         $display("FAIL ovr_17th: got count %0d ovr %b head %h required 16/1/080", rf_count, rf_overrun, rf_data_out);
      end
      lsr_mask = 1'b1;
      @(negedge clk);
      lsr_mask = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rf_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_clear: got %b required 0", rf_overrun);
      end
      rx_reset = 1'b1;
      @(negedge clk);
      rx_reset = 1'b0;
      n_tests++;
      if ({rf_count, rf_error_bit} !== {5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL rx_reset_flush: got count %0d err %b required 0/0", rf_count, rf_error_bit);
      end
      tick(2);
   endtask

   task automatic test_timeout();
      lcr = 8'h03;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      tick(2);
      n_tests++;
      if ({rf_count, timeout_o, rf_data_out} !== {5'd1, 1'b0, 11'h1E0}) begin
         n_fail++;
         $display("FAIL to_entry: got count %0d to %b data %h required 1/0/1e0", rf_count, timeout_o, rf_data_out);
      end
      tick(620);
      n_tests++;
      if (timeout_o !== 1'b0) begin
         n_fail++;
         $display("FAIL to_early: got %b required 0", timeout_o);
      end
      tick(20);
      n_tests++;
      if (timeout_o !== 1'b1) begin
         n_fail++;
         $display("FAIL to_assert: got %b required 1", timeout_o);
      end
      pop_one();
      n_tests++;
      if ({timeout_o, rf_count} !== {1'b0, 5'd0}) begin
         n_fail++;
         $display("FAIL to_pop: got to %b count %0d required 0/0", timeout_o, rf_count);
      end
   endtask

   task automatic test_reset_midframe();
      lcr = 8'h03;
      line(1'b0, 16);
      line(1'b1, 16);
      line(1'b0, 16);
      n_tests++;
      if (rstate !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_state: got %0d required 2", rstate);
      end
      wb_rst_n = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({rstate, rf_count} !== {3'd0, 5'd0}) begin
         n_fail++;
         $display("FAIL mid_reset: got state %0d count %0d required 0/0", rstate, rf_count);
      end
      wb_rst_n  = 1'b1;
      srx_pad_i = 1'b1;
      tick(200);
      pop_one();
      n_tests++;
      if ({rstate, rf_count, rf_data_out} !== {3'd0, 5'd0, 11'h000}) begin
         n_fail++;
         $display("FAIL mid_no_push: got state %0d count %0d data %h required 0/0/000", rstate, rf_count, rf_data_out);
      end
   endtask

   initial begin
      wb_rst_n  = 1'b0;
      enable    = 1'b0;
      srx_pad_i = 1'b1;
      rf_pop    = 1'b0;
      rx_reset  = 1'b0;
      lsr_mask  = 1'b0;
      lcr       = 8'h03;
      test_reset();
      test_8n1();
      test_parity();
      test_framing();
      test_glitch();
      test_break();
      test_overrun();
      test_timeout();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
